// File: rtl/instr_sequencer.sv
// Program memory and issue sequencer feeding the cpu core's instr port.
// Loaded over a valid/ready stream, then issues one word per unstalled cycle until the program ends.
module instr_sequencer #(
    parameter int INSTR_W = 13,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               run,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W:0]    prog_len,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HALT
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic               accept;
    logic               issue;
    logic               last_issue;
    logic               run_ok;

    assign load_ready = (state == LOAD) && (prog_len < FULL);
    assign accept     = load_valid && load_ready;
    assign issue      = (state == RUN) && !stall;
    assign last_issue = issue && ({1'b0, pc} == prog_len - (ADDR_W + 1)'(1));
    // An empty program cannot be started from IDLE; HALT always has at least one word.
    assign run_ok     = run && (prog_len != '0);
    assign busy       = (state == LOAD) || (state == RUN);
    assign halted     = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start)  state_nxt = LOAD;
                else if (run_ok) state_nxt = RUN;
            end
            LOAD: begin
                if (accept && (load_last || prog_len == FULL - (ADDR_W + 1)'(1)))
                    state_nxt = IDLE;
            end
            RUN: begin
                if (last_issue) state_nxt = HALT;
            end
            HALT: begin
                if (load_start) state_nxt = LOAD;
                else if (run)   state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            wr_ptr      <= '0;
            prog_len    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr       <= '0;
            instr_valid <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (load_start) begin
                        wr_ptr   <= '0;
                        prog_len <= '0;
                    end else if (run_ok) begin
                        pc <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        prog_len <= prog_len + (ADDR_W + 1)'(1);
                    end
                end
                RUN: begin
                    // pc wraps naturally on a full-depth program.
                    if (!stall) begin
                        instr       <= mem[pc];
                        instr_valid <= 1'b1;
                        pc          <= pc + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the program memory has no reset; its contents survive reset and only loads rewrite it.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= load_data;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized programs,
// checked against a queue-based model of the program and its issue order.
module tb_instr_sequencer;

    typedef logic [12:0] word_t;
    typedef word_t       word_q_t[$];
    typedef bit          bit_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_valid;
    logic [12:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        run;
    logic        stall;
    logic [12:0] instr;
    logic        instr_valid;
    logic [3:0]  pc;
    logic [4:0]  prog_len;
    logic        busy;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    instr_sequencer #(.INSTR_W(13), .DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .run         (run),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .prog_len    (prog_len),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads w; optional idle gaps (load_valid=0, garbage data, stray run) between beats.
    task automatic load_prog(input word_q_t w, input bit use_last, input bit gaps, input string tag);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_cmp++;
        if ({busy, load_ready, prog_len} !== {1'b1, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL %s_load_enter: got busy=%b ready=%b len=%0d, expected 1 1 0",
                     tag, busy, load_ready, prog_len);
        end
        for (int i = 0; i < w.size(); i++) begin
            n_cmp++;
            if (load_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s_ready beat %0d: got %b, expected 1", tag, i, load_ready);
            end
            load_valid = 1'b1;
            load_data  = w[i];
            load_last  = use_last && (i == w.size() - 1);
            step();
            load_valid = 1'b0;
            load_last  = 1'b0;
            n_cmp++;
            if (prog_len !== 5'(i + 1)) begin
                n_err++;
                $display("FAIL %s_len beat %0d: got %0d, expected %0d", tag, i, prog_len, i + 1);
            end
            if (gaps && i != w.size() - 1) begin
                load_data = word_t'($urandom);
                load_last = 1'($urandom);
                run       = 1'($urandom);
                step();
                run       = 1'b0;
                load_last = 1'b0;
                n_cmp++;
                if ({busy, prog_len} !== {1'b1, 5'(i + 1)}) begin
                    n_err++;
                    $display("FAIL %s_gap beat %0d: got busy=%b len=%0d, expected 1 %0d",
                             tag, i, busy, prog_len, i + 1);
                end
            end
        end
        n_cmp++;
        if ({busy, halted, load_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL %s_load_exit: got busy=%b halted=%b ready=%b, expected 0 0 0",
                     tag, busy, halted, load_ready);
        end
    endtask

    // Starts the program and checks each cycle against the expected issue order under stall pattern sq.
    task automatic run_prog(input word_q_t w, input bit_q_t sq, input string tag);
        int    idx  = 0;
        bit    done = 1'b0;
        bit    s;
        bit    ev;
        word_t ei;
        run = 1'b1;
        step();
        run = 1'b0;
        n_cmp++;
        if ({busy, instr_valid, halted} !== 3'b100) begin
            n_err++;
            $display("FAIL %s_run_enter: got busy=%b valid=%b halted=%b, expected 1 0 0",
                     tag, busy, instr_valid, halted);
        end
        for (int c = 0; c < 100 && !done; c++) begin
            s     = (c < sq.size()) ? sq[c] : 1'b0;
            stall = s;
            step();
            if (s) begin
                ev = 1'b0;
                ei = '0;
            end else begin
                ev = 1'b1;
                ei = w[idx];
                idx++;
            end
            n_cmp++;
            if ({instr_valid, instr, pc} !== {ev, ei, 4'(idx % 16)}) begin
                n_err++;
                $display("FAIL %s_issue cycle %0d: got v=%b i=%h pc=%0d, expected v=%b i=%h pc=%0d",
                         tag, c, instr_valid, instr, pc, ev, ei, idx % 16);
            end
            if (idx == w.size()) done = 1'b1;
        end
        stall = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: issued %0d of %0d words", tag, idx, w.size());
        end
        stall = 1'($urandom);
        step();
        stall = 1'b0;
        n_cmp++;
        if ({halted, busy, instr_valid, instr, pc, prog_len} !==
            {1'b1, 1'b0, 1'b0, 13'h0, 4'(w.size() % 16), 5'(w.size())}) begin
            n_err++;
            $display("FAIL %s_halt: got h=%b b=%b v=%b i=%h pc=%0d len=%0d, expected 1 0 0 0 %0d %0d",
                     tag, halted, busy, instr_valid, instr, pc, prog_len, w.size() % 16, w.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        run = 1'b0; stall = 1'b0;
        step();
        step();
        n_cmp++;
        if ({instr, instr_valid, load_ready, busy, halted, pc, prog_len} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got i=%h v=%b r=%b b=%b h=%b pc=%0d len=%0d, expected all 0",
                     instr, instr_valid, load_ready, busy, halted, pc, prog_len);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        word_q_t w  = '{13'h1A05, 13'h0C8B, 13'h1FFF};
        bit_q_t  sq = '{};
        load_prog(w, 1'b1, 1'b0, "basic");
        run_prog(w, sq, "basic");
    endtask

    task automatic test_stall();
        word_q_t w  = '{13'h1A05, 13'h0C8B, 13'h1FFF};
        bit_q_t  sq = '{1'b0, 1'b1, 1'b0, 1'b0};
        run_prog(w, sq, "stall");
    endtask

    task automatic test_full_depth();
        word_q_t w;
        bit_q_t  sq = '{};
        for (int i = 0; i < 16; i++) w.push_back(word_t'($urandom));
        load_prog(w, 1'b0, 1'b0, "full");
        load_valid = 1'b1;
        load_data  = ~w[0];
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_cmp++;
        if ({prog_len, busy, load_ready} !== {5'd16, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL full_extra_beat: got len=%0d busy=%b ready=%b, expected 16 0 0",
                     prog_len, busy, load_ready);
        end
        run_prog(w, sq, "full");
    endtask

    task automatic test_empty_and_priority();
        word_q_t w  = '{13'h0042, 13'h1001};
        bit_q_t  sq = '{};
        reset = 1'b1;
        #2;
        reset = 1'b0;
        run   = 1'b1;
        step();
        run   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({busy, halted, instr_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL empty_run cycle %0d: got b=%b h=%b v=%b, expected 0 0 0",
                         c, busy, halted, instr_valid);
            end
            step();
        end
        load_prog(w, 1'b1, 1'b0, "prio");
        run_prog(w, sq, "prio");
        load_start = 1'b1;
        run        = 1'b1;
        step();
        load_start = 1'b0;
        run        = 1'b0;
        n_cmp++;
        if ({busy, load_ready, halted, instr_valid, prog_len} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL prio_load_wins: got b=%b r=%b h=%b v=%b len=%0d, expected 1 1 0 0 0",
                     busy, load_ready, halted, instr_valid, prog_len);
        end
        w = '{13'h0777, 13'h1ABC, 13'h0001};
        load_prog(w, 1'b1, 1'b0, "prio2");
        run_prog(w, sq, "prio2");
    endtask

    task automatic test_valid_toggle();
        word_q_t w;
        bit_q_t  sq = '{};
        for (int i = 0; i < 3; i++) w.push_back(word_t'($urandom));
        load_prog(w, 1'b1, 1'b1, "toggle");
        run_prog(w, sq, "toggle");
    endtask

    task automatic test_reset_mid_run();
        word_q_t w;
        bit_q_t  sq = '{};
        int      n  = $urandom_range(5, 10);
        for (int i = 0; i < n; i++) w.push_back(word_t'($urandom));
        load_prog(w, 1'b1, 1'b0, "midrst");
        run   = 1'b1;
        step();
        run   = 1'b0;
        stall = 1'b0;
        step();
        step();
        n_cmp++;
        if ({instr_valid, instr, pc} !== {1'b1, w[1], 4'd2}) begin
            n_err++;
            $display("FAIL midrst_pre: got v=%b i=%h pc=%0d, expected 1 %h 2", instr_valid, instr, pc, w[1]);
        end
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({instr_valid, instr, pc, busy, halted, prog_len} !== '0) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b i=%h pc=%0d b=%b h=%b len=%0d, expected all 0",
                     instr_valid, instr, pc, busy, halted, prog_len);
        end
        step();
        reset = 1'b0;
        run   = 1'b1;
        step();
        run   = 1'b0;
        step();
        n_cmp++;
        if ({busy, instr_valid, halted} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_empty_run: got b=%b v=%b h=%b, expected 0 0 0", busy, instr_valid, halted);
        end
        w = '{};
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) w.push_back(word_t'($urandom));
        load_prog(w, 1'b1, 1'b0, "midrst2");
        run_prog(w, sq, "midrst2");
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            word_q_t w;
            bit_q_t  sq;
            int      n        = $urandom_range(1, 16);
            bit      use_last = (n < 16) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < n; i++) w.push_back(word_t'($urandom));
            for (int i = 0; i < 2 * n; i++) sq.push_back($urandom_range(0, 3) == 0);
            load_prog(w, use_last, 1'($urandom), $sformatf("rand%0d", t));
            run_prog(w, sq, $sformatf("rand%0d", t));
            if ($urandom_range(0, 1) == 1) run_prog(w, '{}, $sformatf("rerun%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full_depth();
        test_empty_and_priority();
        test_valid_toggle();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction source for the 8-bit cpu core. Holds a small program memory, loaded over a valid/ready stream, and drives the core's 13-bit instr input.
- Once started, issues one instruction per unstalled cycle from address 0 up to the last loaded word, then halts.
- Sits directly upstream of cpu: its instr output connects to cpu.instr, on the same clk/reset.

Parameters:
INSTR_W, 13, instruction width (matches cpu instr port)
DEPTH, 16, program memory entries
ADDR_W, 4, address width, log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
load_start  input  1  single-cycle pulse; enter load mode
load_valid  input  1  load beat valid
load_data  input  INSTR_W  instruction word for current beat
load_last  input  1  marks final beat of program
load_ready  output  1  sequencer accepts a beat this cycle
run  input  1  single-cycle pulse; start execution at address 0
stall  input  1  hold issue this cycle
instr  output  INSTR_W  instruction to cpu; 0 when instr_valid=0
instr_valid  output  1  instr carries a real instruction this cycle
pc  output  ADDR_W  address of next instruction to issue
prog_len  output  ADDR_W+1  number of loaded words
busy  output  1  state is LOAD or RUN
halted  output  1  state is HALT

Behaviour:
- Reset (async, any state, including mid-load or mid-run):
  - state=IDLE.
  - pc=0, wr_ptr=0, prog_len=0.
  - instr=0, instr_valid=0, load_ready=0, busy=0, halted=0.
  - Memory contents are not cleared.
- States: IDLE, LOAD, RUN, HALT. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - load_start -> LOAD; wr_ptr=0, prog_len=0.
  - run with prog_len>0 -> RUN; pc=0.
  - run with prog_len=0 is ignored.
  - load_start and run in the same cycle: load_start wins.
- LOAD:
  - load_ready=1 while prog_len<DEPTH.
  - Beat accepted when load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr++, prog_len++.
  - Accepted beat with load_last=1 -> IDLE.
  - Accepting the DEPTH-th beat -> IDLE regardless of load_last; load_ready drops the following cycle; no wrap-around.
  - load_valid while load_ready=0 is not accepted and data is dropped.
  - run and load_start are ignored in LOAD.
- RUN:
  - Each cycle with stall=0: instr<=mem[pc], instr_valid<=1, pc<=pc+1.
  - Each cycle with stall=1: instr<=0, instr_valid<=0, pc holds.
  - Issuing the word at pc=prog_len-1 -> HALT next edge. pc wraps to 0 if prog_len=DEPTH, otherwise shows prog_len.
  - run and load_start are ignored in RUN.
- Latency: run sampled at edge N -> state RUN. With stall=0 at edge N+1, instr=mem[0] and instr_valid=1 after edge N+1. Steady state: one instruction per cycle, no bubbles.
- HALT:
  - instr=0, instr_valid=0, halted=1.
  - run -> RUN with pc=0, re-executing the same program.
  - load_start -> LOAD.
  - load_start and run in the same cycle: load_start wins.
- Instruction contents are opaque. No decoding of bit 12 (immediate flag) or other fields; words pass through bit-exact.
- prog_len is updated only in LOAD and stays stable through RUN/HALT.

Test Plan:
- Reset, then load_start, then 3 beats 13'h1A05, 13'h0C8B, 13'h1FFF (last on beat 3), then run with stall=0 -> instr_valid high for exactly 3 consecutive cycles carrying 13'h1A05, 13'h0C8B, 13'h1FFF; prog_len=3; then halted=1, instr=0.
- Same program, stall=1 on the 2nd issue cycle only -> sequence 1A05, bubble (instr=0, valid=0, pc=1), 0C8B, 1FFF; total 4 cycles.
- Load 16 beats with load_last never asserted -> load_ready=0 after the 16th accept; 17th beat dropped; state IDLE; run issues all 16 words in order; pc wraps to 0.
- run with prog_len=0 -> no instr_valid ever, state stays IDLE. load_start+run in the same cycle from HALT -> LOAD entered, load_ready=1.
- Load 3 words with load_valid toggling 1,0,1,0,1 -> exactly 3 writes, in order.
- Assert reset mid-RUN after 2 issues, with no clk edge -> instr_valid=0, pc=0, state IDLE immediately. run with prog_len=0 is then ignored. A fresh load then run reissues correctly, confirming memory retention does not corrupt sequencing.
